timer_apb_sequencer: RTL
========================

# timer_apb_sequencer

APB-master controller that programs and supervises the 8-bit timer through its register interface (TDR 0x00, TCR 0x01, TSR 0x02). It accepts one timer command at a time, then issues the load/enable write sequence. Optionally it polls TSR for overflow/underflow, clears the flag by write-1-to-clear and reports the event. It sits between firmware-facing command logic and the timer's APB slave port, so nothing else drives that port.

## Interface
- POLL_GAP, 4: idle cycles between consecutive TSR reads (0 allowed).
- TIMEOUT, 255: max TSR reads per command before giving up (1..65535).
- pclk  in  1  clock; all logic on rising edge.
- preset_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready at an edge.
- cmd_tdr  in  8  timer load value.
- cmd_dir  in  1  0 = count up, 1 = count down (TCR bit5).
- cmd_cks  in  2  clock select (TCR bits1:0).
- cmd_poll  in  1  1 = wait for a TSR event after enabling.
- done  out  1  one-cycle pulse at command completion.
- evt_flags  out  2  TSR[1:0] captured on hit (bit0 overflow, bit1 underflow), valid with done.
- err  out  1  valid with done: pslverr seen or poll timeout.
- psel, penable, pwrite  out  1 each  APB master control.
- paddr  out  8  APB address.
- pwdata  out  8  APB write data.
- prdata  in  8  APB read data.
- pready, pslverr  in  1 each  APB completion / error.

## Operation
- Command fields are latched at accept; inputs are ignored while busy.
- TCR image: bit7 load, bit5 dir, bit4 enable, bits1:0 cks, all other bits 0.
- States: IDLE, WR_TDR, WR_LOAD, WR_EN, POLL_WAIT, RD_TSR, WR_CLR, WR_STOP, DONE. Each APB state has a SETUP and an ACCESS phase.
- IDLE -> WR_TDR on accept. WR_TDR writes TDR = cmd_tdr.
- WR_LOAD writes TCR = 0x80 | dir<<5 | cks.
- WR_EN writes TCR = 0x10 | dir<<5 | cks.
- After WR_EN: go to POLL_WAIT if cmd_poll, else to DONE.
- POLL_WAIT counts POLL_GAP cycles, then goes to RD_TSR. RD_TSR reads addr 0x02 and increments the 16-bit poll counter.
- If prdata[1:0] != 0: capture as flags, go to WR_CLR. WR_CLR writes TSR = {6'b0, flags}, then DONE with err=0.
- If prdata[1:0] == 0 and poll count < TIMEOUT: back to POLL_WAIT.
- If prdata[1:0] == 0 and poll count == TIMEOUT: go to WR_STOP. WR_STOP writes TCR = dir<<5 | cks (enable off), then DONE with err=1, flags=0.
- prdata[7:2] are ignored.
- pslverr=1 at any transfer completion: skip all remaining transfers and go to DONE with err=1, flags=0.
- DONE asserts done for one cycle, then returns to IDLE. evt_flags and err hold until the next accept.

## Timing
- APB SETUP: psel=1, penable=0, for one cycle.
- APB ACCESS: psel=1, penable=1, held until pready=1. The transfer completes at the edge where pready=1.
- paddr, pwrite and pwdata are stable from SETUP through completion.
- The next transfer's SETUP begins the cycle immediately after completion, with no idle cycle.
- Zero-wait, no-poll case: accept at edge 0, SETUP in cycles 1/3/5, ACCESS in cycles 2/4/6, done high in cycle 7, cmd_ready high in cycle 8.
- Each pready=0 cycle extends the sequence by one cycle.
- Poll period with zero-wait APB: POLL_GAP + 2 cycles per TSR read.
- Reset (preset_n=0 sampled at an edge): next cycle has psel=penable=pwrite=0, paddr=pwdata=0, done=err=0, evt_flags=0, cmd_ready=0, counters cleared, state IDLE.
- cmd_ready rises the first cycle after preset_n is sampled high.
- Reset mid-transfer aborts immediately; the timer's state is left as-is.

## Test plan
- No-poll, zero-wait: cmd_tdr=0xA5, dir=1, cks=2 -> writes (0x00,0xA5), (0x01,0xA2), (0x01,0x32); done in cycle 7; err=0.
- Poll hit: dir=0, cks=1, POLL_GAP=4; slave returns TSR=0x00 twice, then 0xFD -> third read captures flags=2'b01; write (0x02,0x01); done with evt_flags=01, err=0; reads are 6 cycles apart.
- Timeout: TIMEOUT=3, TSR always 0x00 -> exactly 3 reads, then write (0x01, dir<<5|cks, bit4=0); done with err=1, evt_flags=00.
- Wait states and error: pready low for 3 cycles on the WR_LOAD access -> all signals stable, sequence delayed by 3 cycles. pslverr=1 on WR_EN -> no further transfers, done with err=1.
- Reset and back-pressure: preset_n low during WR_LOAD ACCESS -> psel=0 the next cycle and all outputs at reset values. Then cmd_valid is held high across busy -> exactly one command accepted per IDLE, cmd_ready=0 from accept through done.

Source files
------------

// File: rtl/timer_apb_sequencer.sv
// APB master that loads and enables the 8-bit timer, optionally polls TSR for
// an overflow/underflow event, clears it (W1C) and reports completion.
//   state     | meaning
//   IDLE      | cmd_ready high, waiting for a command
//   WR_TDR    | write load value to TDR
//   WR_LOAD   | write TCR with load bit
//   WR_EN     | write TCR with enable bit
//   POLL_WAIT | idle gap between TSR reads
//   RD_TSR    | read TSR, check flags
//   WR_CLR    | write-1-to-clear captured flags
//   WR_STOP   | poll timeout, disable timer
//   DONE      | one-cycle done pulse
module timer_apb_sequencer #(
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_tdr,
  input  logic       cmd_dir,
  input  logic [1:0] cmd_cks,
  input  logic       cmd_poll,
  output logic       done,
  output logic [1:0] evt_flags,
  output logic       err,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr
);

  typedef enum logic [3:0] {
    IDLE, WR_TDR, WR_LOAD, WR_EN, POLL_WAIT, RD_TSR, WR_CLR, WR_STOP, DONE
  } state_t;

  localparam bit          GAP_ZERO    = (POLL_GAP == 0);
  localparam logic [15:0] GAP_LOAD    = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      state;
  logic        dir_q;
  logic [1:0]  cks_q;
  logic        poll_q;
  logic [1:0]  flags_q;
  logic [15:0] poll_cnt;
  logic [15:0] gap_cnt;
  logic [15:0] poll_nxt;

  assign poll_nxt = poll_cnt + 16'd1;

  wire unused_ok = &{1'b0, prdata[7:2]};

  // {pwrite, paddr, pwdata} for the transfer issued by each APB state
  function automatic logic [16:0] xfer(input state_t st, input logic [7:0] tdr,
                                       input logic dir, input logic [1:0] cks,
                                       input logic [1:0] flg);
    logic [7:0] tcr;
    tcr = {2'b00, dir, 3'b000, cks};
    case (st)
      WR_TDR:  xfer = {1'b1, 8'h00, tdr};
      WR_LOAD: xfer = {1'b1, 8'h01, tcr | 8'h80};
      WR_EN:   xfer = {1'b1, 8'h01, tcr | 8'h10};
      RD_TSR:  xfer = {1'b0, 8'h02, 8'h00};
      WR_CLR:  xfer = {1'b1, 8'h02, {6'b0, flg}};
      WR_STOP: xfer = {1'b1, 8'h01, tcr};
      default: xfer = '0;
    endcase
  endfunction

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      evt_flags <= 2'b00;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 8'h00;
      pwdata    <= 8'h00;
      dir_q     <= 1'b0;
      cks_q     <= 2'b00;
      poll_q    <= 1'b0;
      flags_q   <= 2'b00;
      poll_cnt  <= 16'd0;
      gap_cnt   <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            dir_q     <= cmd_dir;
            cks_q     <= cmd_cks;
            poll_q    <= cmd_poll;
            poll_cnt  <= 16'd0;
            err       <= 1'b0;
            evt_flags <= 2'b00;
            state     <= WR_TDR;
            psel      <= 1'b1;
            penable   <= 1'b0;
            {pwrite, paddr, pwdata} <= xfer(WR_TDR, cmd_tdr, cmd_dir, cmd_cks, 2'b00);
          end
        end
        POLL_WAIT: begin
          if (gap_cnt == 16'd0) begin
            state <= RD_TSR;
            psel  <= 1'b1;
            {pwrite, paddr, pwdata} <= xfer(RD_TSR, 8'h00, dir_q, cks_q, 2'b00);
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          if (!penable) begin
            penable <= 1'b1;
          end else if (pready) begin
            // Bus goes idle on completion unless a branch below starts the next SETUP.
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= 8'h00;
            pwdata  <= 8'h00;
            if (pslverr) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              case (state)
                WR_TDR: begin
                  state <= WR_LOAD;
                  psel  <= 1'b1;
                  {pwrite, paddr, pwdata} <= xfer(WR_LOAD, 8'h00, dir_q, cks_q, 2'b00);
                end
                WR_LOAD: begin
                  state <= WR_EN;
                  psel  <= 1'b1;
                  {pwrite, paddr, pwdata} <= xfer(WR_EN, 8'h00, dir_q, cks_q, 2'b00);
                end
                WR_EN, RD_TSR: begin
                  if (state == RD_TSR) poll_cnt <= poll_nxt;
                  if (state == WR_EN && !poll_q) begin
                    state <= DONE;
                    done  <= 1'b1;
                  end else if (state == RD_TSR && prdata[1:0] != 2'b00) begin
                    state   <= WR_CLR;
                    flags_q <= prdata[1:0];
                    psel    <= 1'b1;
                    {pwrite, paddr, pwdata} <= xfer(WR_CLR, 8'h00, dir_q, cks_q, prdata[1:0]);
                  end else if (state == RD_TSR && poll_nxt == TIMEOUT_CNT) begin
                    state <= WR_STOP;
                    psel  <= 1'b1;
                    {pwrite, paddr, pwdata} <= xfer(WR_STOP, 8'h00, dir_q, cks_q, 2'b00);
                  end else if (GAP_ZERO) begin
                    state <= RD_TSR;
                    psel  <= 1'b1;
                    {pwrite, paddr, pwdata} <= xfer(RD_TSR, 8'h00, dir_q, cks_q, 2'b00);
                  end else begin
                    state   <= POLL_WAIT;
                    gap_cnt <= GAP_LOAD;
                  end
                end
                WR_CLR: begin
                  state     <= DONE;
                  done      <= 1'b1;
                  evt_flags <= flags_q;
                end
                WR_STOP: begin
                  state <= DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
                end
                default: state <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
